// File: rtl/pe_mem_driver_pkg.sv
// pe_mem_driver_pkg: shared sizes, FSM states and a range helper
// for the PE memory driver and its scratch store.
package pe_mem_driver_pkg;

  localparam int DATA_SIZE        = 8;
  localparam int BIGGER_DATA_SIZE = 10;
  localparam int FILTER_W         = 3;
  localparam int IFMAP_MAX        = 8;
  localparam int ADDR_W           = 3;
  localparam int LEN_W            = 4;
  localparam int IDX_W            = 3;

  typedef enum logic [2:0] {
    IDLE,
    STREAM,
    WAIT,
    OUT,
    DONE
  } state_t;

  function automatic logic in_range(
    input int v,
    input int lo,
    input int hi
  );
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/pe_mem_driver_if.sv
// pe_mem_driver_if: PE tap/psum wires plus the result stream.
// master/mem = driver side, slave = PE and result sink side.
interface pe_mem_driver_if;
  import pe_mem_driver_pkg::*;

  logic signed [DATA_SIZE-1:0]        filter_i;
  logic signed [DATA_SIZE-1:0]        ifmap_i;
  logic signed [BIGGER_DATA_SIZE-1:0] psum_i;
  logic signed [BIGGER_DATA_SIZE-1:0] psum_o;
  logic                               psum_valid_o;
  logic                               out_valid;
  logic                               out_ready;
  logic signed [BIGGER_DATA_SIZE-1:0] out_data;
  logic [IDX_W-1:0]                   out_idx;

  modport master (
    output filter_i, ifmap_i, psum_i,
    output out_valid, out_data, out_idx,
    input  psum_o, psum_valid_o, out_ready
  );

  modport mem (
    output filter_i, ifmap_i, psum_i,
    output out_valid, out_data, out_idx,
    input  psum_o, psum_valid_o, out_ready
  );

  modport slave (
    input  filter_i, ifmap_i, psum_i,
    input  out_valid, out_data, out_idx,
    output psum_o, psum_valid_o, out_ready
  );

endinterface

// File: rtl/pe_scratch.sv
// pe_scratch: filter and ifmap scratch arrays.
// Ports: i_we/i_sel/i_addr/i_wdata write (sync); i_f_raddr and
// i_i_raddr read (async) to o_f_rdata/o_i_rdata; rst clears (async).
module pe_scratch #(
  parameter int DATA_SIZE = 8,
  parameter int FILTER_W  = 3,
  parameter int IFMAP_MAX = 8,
  parameter int ADDR_W    = 3,
  parameter int TAP_W     = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_we,
  input  logic                        i_sel,
  input  logic [ADDR_W-1:0]           i_addr,
  input  logic signed [DATA_SIZE-1:0] i_wdata,
  input  logic [TAP_W-1:0]            i_f_raddr,
  input  logic [ADDR_W-1:0]           i_i_raddr,
  output logic signed [DATA_SIZE-1:0] o_f_rdata,
  output logic signed [DATA_SIZE-1:0] o_i_rdata
);

  logic signed [DATA_SIZE-1:0] r_filter [FILTER_W];
  logic signed [DATA_SIZE-1:0] r_ifmap  [IFMAP_MAX];

  logic w_f_we;
  logic w_i_we;

  // out-of-range filter addresses are dropped silently
  assign w_f_we = i_we && !i_sel
               && (int'(i_addr) < FILTER_W);
  assign w_i_we = i_we && i_sel
               && (int'(i_addr) < IFMAP_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FILTER_W; i++)
        r_filter[i] <= '0;
      for (int i = 0; i < IFMAP_MAX; i++)
        r_ifmap[i] <= '0;
    end else begin
      if (w_f_we)
        r_filter[i_addr[TAP_W-1:0]] <= i_wdata;
      if (w_i_we)
        r_ifmap[i_addr] <= i_wdata;
    end
  end

  assign o_f_rdata = (int'(i_f_raddr) < FILTER_W)
                   ? r_filter[i_f_raddr] : '0;
  assign o_i_rdata = (int'(i_i_raddr) < IFMAP_MAX)
                   ? r_ifmap[i_i_raddr] : '0;

endmodule

// File: rtl/pe_mem_driver.sv
// pe_mem_driver: streams filter/ifmap taps into one PE per window,
// collects each psum and emits it on a valid/ready result stream.
// Ports: clk, rst (async high); cfg_* scratch writes (IDLE only);
// ifmap_len, psum_bias, start in; busy, done, err out;
// bus (mem modport): PE taps, psum_i, PE psum return, result stream.
module pe_mem_driver #(
  parameter int DATA_SIZE        = pe_mem_driver_pkg::DATA_SIZE,
  parameter int BIGGER_DATA_SIZE = pe_mem_driver_pkg::BIGGER_DATA_SIZE,
  parameter int FILTER_W         = pe_mem_driver_pkg::FILTER_W,
  parameter int IFMAP_MAX        = pe_mem_driver_pkg::IFMAP_MAX
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cfg_we,
  input  logic                               cfg_sel,
  input  logic [2:0]                         cfg_addr,
  input  logic signed [DATA_SIZE-1:0]        cfg_data,
  input  logic [3:0]                         ifmap_len,
  input  logic signed [BIGGER_DATA_SIZE-1:0] psum_bias,
  input  logic                               start,
  output logic                               busy,
  output logic                               done,
  output logic                               err,
  pe_mem_driver_if.mem                       bus
);
  import pe_mem_driver_pkg::*;

  localparam int TAP_W = $clog2(FILTER_W + 1);

  state_t r_state;
  state_t w_state_nx;

  logic [IDX_W-1:0]                   r_k;
  logic [IDX_W-1:0]                   w_k_nx;
  logic [TAP_W-1:0]                   r_t;
  logic [TAP_W-1:0]                   w_t_nx;
  logic [LEN_W-1:0]                   r_len;
  logic [LEN_W-1:0]                   w_len_nx;
  logic signed [BIGGER_DATA_SIZE-1:0] r_result;
  logic signed [BIGGER_DATA_SIZE-1:0] w_result_nx;
  logic                               r_err;
  logic                               w_err_nx;

  logic                        w_cfg_we;
  logic                        w_len_ok;
  logic                        w_last_tap;
  logic [IDX_W-1:0]            w_last_k;
  logic [ADDR_W-1:0]           w_i_raddr;
  logic signed [DATA_SIZE-1:0] w_f_rdata;
  logic signed [DATA_SIZE-1:0] w_i_rdata;

  assign w_cfg_we   = cfg_we && (r_state == IDLE);
  assign w_len_ok   = in_range(int'(ifmap_len),
                               FILTER_W, IFMAP_MAX);
  assign w_last_tap = (r_t == TAP_W'(FILTER_W - 1));
  // index of the final window: len - FILTER_W
  assign w_last_k   = IDX_W'(r_len - LEN_W'(FILTER_W));
  assign w_i_raddr  = ADDR_W'(r_k) + ADDR_W'(r_t);

  pe_scratch #(
    .DATA_SIZE (DATA_SIZE),
    .FILTER_W  (FILTER_W),
    .IFMAP_MAX (IFMAP_MAX),
    .ADDR_W    (ADDR_W),
    .TAP_W     (TAP_W)
  ) u_scratch (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_cfg_we),
    .i_sel     (cfg_sel),
    .i_addr    (cfg_addr),
    .i_wdata   (cfg_data),
    .i_f_raddr (r_t),
    .i_i_raddr (w_i_raddr),
    .o_f_rdata (w_f_rdata),
    .o_i_rdata (w_i_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_k      <= '0;
      r_t      <= '0;
      r_len    <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_k      <= w_k_nx;
      r_t      <= w_t_nx;
      r_len    <= w_len_nx;
      r_result <= w_result_nx;
      r_err    <= w_err_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_k_nx      = r_k;
    w_t_nx      = r_t;
    w_len_nx    = r_len;
    w_result_nx = r_result;
    w_err_nx    = r_err;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_len_nx = ifmap_len;
          w_k_nx   = '0;
          w_t_nx   = '0;
          if (w_len_ok) begin
            w_state_nx = STREAM;
            w_err_nx   = 1'b0;
          end else begin
            w_state_nx = DONE;
            w_err_nx   = 1'b1;
          end
        end
      end
      STREAM: begin
        if (w_last_tap)
          w_state_nx = WAIT;
        else
          w_t_nx = r_t + TAP_W'(1);
      end
      WAIT: begin
        // psum_valid is only honoured here
        if (bus.psum_valid_o) begin
          w_result_nx = bus.psum_o;
          w_state_nx  = OUT;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          if (r_k == w_last_k) begin
            w_state_nx = DONE;
          end else begin
            w_k_nx     = r_k + IDX_W'(1);
            w_t_nx     = '0;
            w_state_nx = STREAM;
          end
        end
      end
      DONE: begin
        w_state_nx = IDLE;
        w_err_nx   = 1'b0;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);
  assign err  = done && r_err;

  assign bus.filter_i  = (r_state == STREAM)
                       ? w_f_rdata : '0;
  assign bus.ifmap_i   = (r_state == STREAM)
                       ? w_i_rdata : '0;
  assign bus.psum_i    = psum_bias;
  assign bus.out_valid = (r_state == OUT);
  assign bus.out_data  = r_result;
  assign bus.out_idx   = r_k;

endmodule

// File: tb/tb_pe_mem_driver.sv
// tb_pe_mem_driver: randomized + directed bench with a PE model,
// reference scoreboard queues and a decoupled negedge monitor.
module tb_pe_mem_driver;
  import pe_mem_driver_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                               rst;
  logic                               cfg_we;
  logic                               cfg_sel;
  logic [2:0]                         cfg_addr;
  logic signed [DATA_SIZE-1:0]        cfg_data;
  logic [3:0]                         ifmap_len;
  logic signed [BIGGER_DATA_SIZE-1:0] psum_bias;
  logic                               start;
  logic                               busy;
  logic                               done;
  logic                               err;

  pe_mem_driver_if bus ();

  pe_mem_driver dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .ifmap_len (ifmap_len),
    .psum_bias (psum_bias),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .bus       (bus)
  );

  typedef struct { int f; int i; } tap_t;
  typedef struct { int data; int idx; } res_t;

  tap_t tap_q[$];
  res_t res_q[$];
  int   err_q[$];

  int m_filter [FILTER_W];
  int m_ifmap  [IFMAP_MAX];

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;
  int taps_seen   = 0;
  int cyc         = 0;
  int fire_cyc    = -10;
  int cur_bias    = 0;
  int pe_delay    = 2;
  int ready_mode  = 0;
  bit stray_mode  = 0;
  bit aborted     = 0;

  function automatic void chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d",
               name, act, exp);
    end
  endfunction

  function automatic void bad(string name, int act);
    vectors++;
    miscompares++;
    $display("FAIL %s: got %0d, expected none", name, act);
  endfunction

  function automatic void chk_idle_outputs(string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
    chk({tag, "_out_data"}, int'(bus.out_data), 0);
    chk({tag, "_out_idx"}, int'(bus.out_idx), 0);
    chk({tag, "_pe_filter"}, int'(bus.filter_i), 0);
    chk({tag, "_pe_ifmap"}, int'(bus.ifmap_i), 0);
  endfunction

  function automatic int rnd_nz();
    int v;
    v = int'($urandom_range(1, 12));
    if ($urandom_range(0, 1) == 1) v = -v;
    return v;
  endfunction

  task automatic cycle_counter();
    forever begin
      @(posedge clk);
      cyc++;
    end
  endtask

  // PE stand-in: sums the taps it sees, answers after pe_delay
  task automatic pe_model();
    int acc;
    int cnt;
    int cd;
    acc = 0;
    cnt = 0;
    cd  = 0;
    forever begin
      @(negedge clk);
      bus.psum_valid_o = 1'b0;
      if (rst) begin
        acc = 0;
        cnt = 0;
        cd  = 0;
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            bus.psum_valid_o = 1'b1;
            bus.psum_o = BIGGER_DATA_SIZE'(
              acc + int'(bus.psum_i));
            fire_cyc = cyc;
            acc = 0;
          end
        end
        if (bus.filter_i != 0) begin
          acc += int'(bus.filter_i) * int'(bus.ifmap_i);
          cnt++;
          if (stray_mode && (cnt == 1 || cnt == FILTER_W)) begin
            bus.psum_valid_o = 1'b1;
            bus.psum_o = BIGGER_DATA_SIZE'(
              $urandom_range(600, 900));
          end
          if (cnt == FILTER_W) begin
            cnt = 0;
            cd  = pe_delay;
          end
        end
      end
    end
  endtask

  task automatic ready_drv();
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0)
        bus.out_ready = 1'b1;
      else if (ready_mode == 1)
        bus.out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic monitor();
    tap_t e;
    res_t r;
    int   pv_data;
    int   pv_idx;
    bit   pv_stall;
    pv_stall = 0;
    pv_data  = 0;
    pv_idx   = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv_stall = 0;
      end else begin
        if (bus.filter_i != 0) begin
          taps_seen++;
          if (bus.out_valid)
            bad("tap_during_out", int'(bus.filter_i));
          if (tap_q.size() == 0) begin
            bad("unexpected_tap", int'(bus.filter_i));
          end else begin
            e = tap_q.pop_front();
            chk("tap_filter", int'(bus.filter_i), e.f);
            chk("tap_ifmap", int'(bus.ifmap_i), e.i);
            chk("pe_psum_bias", int'(bus.psum_i), cur_bias);
          end
        end else if (bus.ifmap_i != 0) begin
          bad("ifmap_without_tap", int'(bus.ifmap_i));
        end
        if (cyc == fire_cyc + 1)
          chk("out_valid_latency", int'(bus.out_valid), 1);
        if (bus.out_valid) begin
          if (pv_stall) begin
            chk("stall_data", int'(bus.out_data), pv_data);
            chk("stall_idx", int'(bus.out_idx), pv_idx);
          end
          if (bus.out_ready) begin
            pv_stall = 0;
            if (res_q.size() == 0) begin
              bad("unexpected_out", int'(bus.out_data));
            end else begin
              r = res_q.pop_front();
              chk("out_data", int'(bus.out_data), r.data);
              chk("out_idx", int'(bus.out_idx), r.idx);
            end
          end else begin
            pv_stall = 1;
            pv_data  = int'(bus.out_data);
            pv_idx   = int'(bus.out_idx);
          end
        end else begin
          pv_stall = 0;
        end
        if (done) begin
          done_cnt++;
          if (err_q.size() == 0) begin
            bad("unexpected_done", int'(err));
          end else begin
            chk("done_err", int'(err), err_q.pop_front());
            chk("taps_left", tap_q.size(), 0);
            chk("results_left", res_q.size(), 0);
          end
        end else if (err) begin
          bad("err_without_done", 1);
        end
      end
    end
  endtask

  // reference: every window is bias + dot(filter, ifmap slice)
  task automatic expect_run(input int len, input int bias);
    int s;
    if (len >= FILTER_W && len <= IFMAP_MAX) begin
      for (int k = 0; k <= len - FILTER_W; k++) begin
        s = bias;
        for (int t = 0; t < FILTER_W; t++) begin
          tap_q.push_back('{m_filter[t], m_ifmap[k + t]});
          s += m_filter[t] * m_ifmap[k + t];
        end
        res_q.push_back('{s, k});
      end
      err_q.push_back(0);
    end else begin
      err_q.push_back(1);
    end
  endtask

  task automatic cfg_write(
    input bit sel, input int addr,
    input int val, input bit upd
  );
    @(posedge clk);
    #1;
    cfg_we   = 1'b1;
    cfg_sel  = sel;
    cfg_addr = 3'(addr);
    cfg_data = DATA_SIZE'(val);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    if (upd) begin
      if (!sel && addr < FILTER_W) m_filter[addr] = val;
      else if (sel) m_ifmap[addr] = val;
    end
  endtask

  task automatic load_123();
    for (int t = 0; t < FILTER_W; t++)
      cfg_write(0, t, t + 1, 1);
    for (int i = 0; i < IFMAP_MAX; i++)
      cfg_write(1, i, (i < 5) ? i + 1 : 7, 1);
  endtask

  task automatic run(input int len, input int bias);
    int d0;
    bit ok;
    ok = (len >= FILTER_W && len <= IFMAP_MAX);
    expect_run(len, bias);
    @(posedge clk);
    #1;
    cur_bias  = bias;
    ifmap_len = 4'(len);
    psum_bias = BIGGER_DATA_SIZE'(bias);
    start     = 1'b1;
    d0        = done_cnt;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (ok) begin
      @(negedge clk);
      chk("first_tap_latency", int'(bus.filter_i),
          m_filter[0]);
    end
    for (int c = 0; c < 600; c++) begin
      if (done_cnt != d0 || aborted) break;
      @(negedge clk);
    end
    if (done_cnt == d0 && !aborted) begin
      bad("run_timeout", len);
      tap_q.delete();
      res_q.delete();
      err_q.delete();
    end
  endtask

  initial begin
    int len;
    int bias;
    rst           = 1'b1;
    cfg_we        = 1'b0;
    cfg_sel       = 1'b0;
    cfg_addr      = '0;
    cfg_data      = '0;
    ifmap_len     = '0;
    psum_bias     = '0;
    start         = 1'b0;
    bus.out_ready = 1'b1;
    bus.psum_o    = '0;
    bus.psum_valid_o = 1'b0;
    fork
      cycle_counter();
      pe_model();
      ready_drv();
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    rst = 1'b0;

    // worked example: 14, 20, 26
    load_123();
    pe_delay = 2;
    run(5, 0);

    // rejected lengths
    run(2, 0);
    run(9, 0);

    // stalled result stream
    ready_mode    = 2;
    bus.out_ready = 1'b0;
    fork
      run(5, 3);
      begin
        for (int c = 0; c < 100; c++) begin
          @(negedge clk);
          if (bus.out_valid) break;
        end
        if (!bus.out_valid) bad("stall_no_valid", 0);
        repeat (5) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    ready_mode = 0;

    // stray PE valids during STREAM
    stray_mode = 1;
    run(5, 0);
    stray_mode = 0;

    // start / cfg_we while busy
    fork
      run(6, -4);
      begin
        repeat (4) @(posedge clk);
        #1;
        start     = 1'b1;
        ifmap_len = 4'd2;
        cfg_we    = 1'b1;
        cfg_sel   = 1'b0;
        cfg_addr  = 3'd0;
        cfg_data  = 8'sd9;
        @(posedge clk);
        #1;
        cfg_sel   = 1'b1;
        cfg_addr  = 3'd2;
        @(posedge clk);
        #1;
        start     = 1'b0;
        cfg_we    = 1'b0;
      end
    join
    run(5, 0);

    // reset while waiting on window 1
    pe_delay = 3;
    aborted  = 0;
    fork
      run(5, 0);
      begin
        int tgt;
        tgt = taps_seen + 2 * FILTER_W;
        for (int c = 0; c < 200; c++) begin
          if (taps_seen >= tgt) break;
          @(posedge clk);
        end
        if (taps_seen < tgt) bad("reset_wait_taps", taps_seen);
        @(posedge clk);
        #1;
        rst     = 1'b1;
        aborted = 1;
        tap_q.delete();
        res_q.delete();
        err_q.delete();
        #1;
        chk_idle_outputs("midrun_rst");
        @(negedge clk);
        chk_idle_outputs("midrun_rst_cycle");
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
    join
    aborted = 0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("after_rst");
    load_123();
    pe_delay = 2;
    run(5, 0);

    // randomized runs
    for (int n = 0; n < 30; n++) begin
      ready_mode = int'($urandom_range(0, 1));
      pe_delay   = int'($urandom_range(1, 4));
      stray_mode = 1'($urandom_range(0, 1));
      for (int t = 0; t < FILTER_W; t++)
        cfg_write(0, t, rnd_nz(), 1);
      cfg_write(0, int'($urandom_range(3, 7)),
                rnd_nz(), 0);
      for (int i = 0; i < IFMAP_MAX; i++)
        cfg_write(1, i, rnd_nz(), 1);
      if ($urandom_range(0, 3) != 0)
        len = int'($urandom_range(3, 8));
      else
        len = int'($urandom_range(0, 15));
      bias = int'($urandom_range(0, 58)) - 29;
      run(len, bias);
    end
    ready_mode = 0;
    stray_mode = 0;
    repeat (4) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
